// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_subtractor_pkg;

    // FSM state encoding; the bench uses the same values for state checks.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Bit-counter width for a given operand width (never narrower than 1 bit).
    function automatic int cnt_width(input int w);
        int r;
        r = $clog2(w);
        if (r < 1) begin
            r = 1;
        end else begin
            r = r;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle between a requester and the serial subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = x - y - z, bo = borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic d,
    output logic bo
);
    assign d  = x ^ y ^ z;
    assign bo = (~x & y) | (~(x ^ y) & z);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: a - b - bin, LSB first, one bit per clock.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int              CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_r;
    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    logic [WIDTH-1:0] sr_r;
    logic [WIDTH-1:0] diff_r;
    logic [CNT_W-1:0] cnt_r;
    logic             br_r;
    logic             bout_r;
    logic             busy_r;
    logic             done_r;
    logic             d_s;
    logic             bo_s;

    // The single arithmetic cell, fed by the operand LSBs and the running borrow.
    full_subtractor u_cell (
        .x  (sa_r[0]),
        .y  (sb_r[0]),
        .z  (br_r),
        .d  (d_s),
        .bo (bo_s)
    );

    // Control FSM, operand/result shift registers, borrow flop and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            sa_r    <= {WIDTH{1'b0}};
            sb_r    <= {WIDTH{1'b0}};
            sr_r    <= {WIDTH{1'b0}};
            diff_r  <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            br_r    <= 1'b0;
            bout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        sa_r    <= bus.a;
                        sb_r    <= bus.b;
                        br_r    <= bus.bin;
                        cnt_r   <= {CNT_W{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= S_RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                S_RUN: begin
                    sr_r <= {d_s, sr_r[WIDTH-1:1]};
                    sa_r <= {1'b0, sa_r[WIDTH-1:1]};
                    sb_r <= {1'b0, sb_r[WIDTH-1:1]};
                    br_r <= bo_s;
                    if (cnt_r == LAST_CNT) begin
                        // Last bit: publish the result; the counter is parked at zero.
                        cnt_r   <= {CNT_W{1'b0}};
                        diff_r  <= {d_s, sr_r[WIDTH-1:1]};
                        bout_r  <= bo_s;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                        state_r <= S_RUN;
                    end
                end
                S_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.diff = diff_r;
    assign bus.bout = bout_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=4 instances).
module tb_serial_subtractor;
    import serial_subtractor_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(4)) bus4 ();

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full 8-bit operation with timing checks; called at a negedge with DUT idle.
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic bin, input logic [7:0] ed, input logic eb);
        int nb;
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        bus8.bin   = bin;
        @(negedge clk);
        bus8.start = 1'b0;
        nb = 0;
        while (bus8.busy === 1'b1 && nb < 40) begin
            chk({tag, "_done_low_while_busy"}, 32'(bus8.done), 32'd0);
            nb++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 32'(nb), 32'd8);
        chk({tag, "_done"}, 32'(bus8.done), 32'd1);
        chk({tag, "_diff"}, 32'(bus8.diff), 32'(ed));
        chk({tag, "_bout"}, 32'(bus8.bout), 32'(eb));
        @(negedge clk);
        chk({tag, "_done_pulse_end"}, 32'(bus8.done), 32'd0);
        @(negedge clk);
        chk({tag, "_back_idle"}, 32'(dut8.state_r), 32'(S_IDLE));
    endtask

    initial begin
        int pulses;
        logic [3:0] pd;
        logic       pb;
        logic [4:0] full;
        int nw;

        checks   = 0;
        failures = 0;

        // 1. Reset with start held high.
        rst        = 1'b1;
        bus8.start = 1'b1;
        bus8.a     = 8'h5A;
        bus8.b     = 8'h23;
        bus8.bin   = 1'b0;
        bus4.start = 1'b1;
        bus4.a     = 4'h5;
        bus4.b     = 4'h3;
        bus4.bin   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus8.busy), 32'd0);
        chk("rst_done", 32'(bus8.done), 32'd0);
        chk("rst_diff", 32'(bus8.diff), 32'h00);
        chk("rst_bout", 32'(bus8.bout), 32'd0);
        chk("rst_state", 32'(dut8.state_r), 32'(S_IDLE));
        chk("rst_state4", 32'(dut4.state_r), 32'(S_IDLE));
        rst        = 1'b0;
        bus8.start = 1'b0;
        bus4.start = 1'b0;
        @(negedge clk);
        chk("idle_hold_busy", 32'(bus8.busy), 32'd0);
        chk("idle_hold_state", 32'(dut8.state_r), 32'(S_IDLE));

        // 2-3. Directed operations.
        op8("t2_5a_23", 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0);
        op8("t3_10_20", 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1);
        op8("t3_00_00_b1", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
        op8("t3_ff_ff", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);

        // 4. Start during RUN is ignored.
        bus8.start = 1'b1;
        bus8.a     = 8'h80;
        bus8.b     = 8'h01;
        bus8.bin   = 1'b0;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (2) @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = 8'h00;
        bus8.b     = 8'hFF;
        @(negedge clk);
        bus8.start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            if (bus8.done === 1'b1) pulses++;
            @(negedge clk);
        end
        chk("t4_one_done", 32'(pulses), 32'd1);
        chk("t4_diff", 32'(bus8.diff), 32'h7F);
        chk("t4_bout", 32'(bus8.bout), 32'd0);
        chk("t4_idle", 32'(dut8.state_r), 32'(S_IDLE));

        // 5. Reset in the middle of RUN.
        bus8.start = 1'b1;
        bus8.a     = 8'h5A;
        bus8.b     = 8'h23;
        bus8.bin   = 1'b0;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_busy_before_rst", 32'(bus8.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_busy", 32'(bus8.busy), 32'd0);
        chk("t5_diff", 32'(bus8.diff), 32'h00);
        chk("t5_bout", 32'(bus8.bout), 32'd0);
        chk("t5_done", 32'(bus8.done), 32'd0);
        chk("t5_state", 32'(dut8.state_r), 32'(S_IDLE));
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus8.done === 1'b1) pulses++;
            @(negedge clk);
        end
        chk("t5_no_done", 32'(pulses), 32'd0);
        op8("t5_09_04_b1", 8'h09, 8'h04, 1'b1, 8'h04, 1'b0);

        // 6. WIDTH=4 exhaustive, next start at the first idle cycle.
        pd = 4'h0;
        pb = 1'b0;
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v          = 9'(i);
            bus4.start = 1'b1;
            bus4.a     = v[8:5];
            bus4.b     = v[4:1];
            bus4.bin   = v[0];
            full       = {1'b0, v[8:5]} - {1'b0, v[4:1]} - {4'b0000, v[0]};
            @(negedge clk);
            bus4.start = 1'b0;
            nw = 0;
            while (bus4.done !== 1'b1 && nw < 20) begin
                chk("t6_diff_stable", 32'(bus4.diff), 32'(pd));
                chk("t6_bout_stable", 32'(bus4.bout), 32'(pb));
                nw++;
                @(negedge clk);
            end
            chk("t6_wait_cycles", 32'(nw), 32'd4);
            chk("t6_diff", 32'(bus4.diff), 32'(full[3:0]));
            chk("t6_bout", 32'(bus4.bout), 32'(full[4]));
            pd = full[3:0];
            pb = full[4];
            @(negedge clk);
            chk("t6_done_pulse_end", 32'(bus4.done), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
